ex_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the EX stage. Accepts one M-op from ID/EX and

---
 rtl/ex_muldiv_seq_pkg.sv | 51 +++++
 rtl/ex_muldiv_seq_if.sv | 26 ++
 rtl/ex_muldiv_seq_dp.sv | 80 ++++++++
 rtl/ex_muldiv_seq.sv | 131 +++++++++++++
 tb/tb_ex_muldiv_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encodings, FSM states and
// operand-signedness helpers.
package ex_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

  function automatic logic op_is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(md_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL keeps the low half, which is identical for signed and unsigned operands.
  function automatic logic op_a_signed(md_op_e op);
    logic s;
    s = 1'b0;
    unique case (op)
      MdMulh, MdMulhsu, MdDiv, MdRem: s = 1'b1;
      default:                        s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_b_signed(md_op_e op);
    logic s;
    s = 1'b0;
    unique case (op)
      MdMulh, MdDiv, MdRem: s = 1'b1;
      default:              s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage request/response bundle between the pipeline (master) and the M-op sequencer (slave).
interface ex_muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport master (
    output start_i, op_i, a_i, b_i, rd_addr_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, rd_addr_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/ex_muldiv_seq_dp.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one register set.
// result_o reflects the value after the current step, so the last step's result can be captured.
module ex_muldiv_seq_dp
  import ex_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] mag_a_i,
  input  logic [XLEN-1:0] mag_b_i,
  input  md_op_e          op_i,
  input  logic            neg_res_i,
  input  logic            neg_rem_i,
  output logic [XLEN-1:0] result_o
);

  // hi: accumulator (mul) / partial remainder (div); lo: multiplier / quotient; opd: addend/divisor
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opd_q;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    sum     = hi_q + {1'b0, (lo_q[0] ? opd_q : '0)};
    shifted = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    trial   = shifted - {1'b0, opd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (op_is_div(op_i)) begin
      // Negative trial (msb set) means the divisor did not fit: restore.
      hi_d = trial[XLEN] ? shifted : trial;
      lo_d = {lo_q[XLEN-2:0], ~trial[XLEN]};
    end else begin
      hi_d = {1'b0, sum[XLEN:1]};
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi_d[XLEN-1:0], lo_d};
    prod_fix = neg_res_i ? -prod : prod;
    quo_fix  = neg_res_i ? -lo_d : lo_d;
    rem_fix  = neg_rem_i ? -hi_d[XLEN-1:0] : hi_d[XLEN-1:0];
    result_o = '0;
    unique case (op_i)
      MdMul:                    result_o = prod_fix[XLEN-1:0];
      MdMulh, MdMulhsu, MdMulhu: result_o = prod_fix[2*XLEN-1:XLEN];
      MdDiv, MdDivu:            result_o = quo_fix;
      MdRem, MdRemu:            result_o = rem_fix;
      default:                  result_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= div_i ? mag_a_i : mag_b_i;
      opd_q <= div_i ? mag_b_i : mag_a_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer beside EX: accepts one M-op, stalls the pipe while iterating
// one bit per cycle, then presents a one-cycle done_o with the registered result.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          DIV_SHORTCUT = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ex_muldiv_seq_if.slave bus
);

  localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  md_state_e       state_q;
  md_op_e          op_q;
  logic [4:0]      rd_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  md_op_e          op_in;
  logic            accept;
  logic            a_neg, b_neg, b_zero, ovf;
  logic            shortcut;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] sc_result;
  logic [XLEN-1:0] dp_result;
  logic            dp_load, dp_step;

  always_comb begin
    op_in    = md_op_e'(bus.op_i);
    accept   = bus.start_i & ~bus.flush_i;
    a_neg    = op_a_signed(op_in) & bus.a_i[XLEN-1];
    b_neg    = op_b_signed(op_in) & bus.b_i[XLEN-1];
    mag_a    = a_neg ? -bus.a_i : bus.a_i;
    mag_b    = b_neg ? -bus.b_i : bus.b_i;
    b_zero   = (bus.b_i == '0);
    ovf      = op_is_div(op_in) & op_a_signed(op_in) &
               (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b_i == '1);
    shortcut = DIV_SHORTCUT & op_is_div(op_in) & (b_zero | ovf);
    sc_result = '0;
    if (b_zero) begin
      sc_result = op_is_rem(op_in) ? bus.a_i : '1;
    end else begin
      sc_result = op_is_rem(op_in) ? '0 : bus.a_i;
    end
  end

  assign dp_load = (state_q == StIdle) & accept & ~shortcut;
  assign dp_step = (state_q == StBusy) & ~bus.flush_i;

  ex_muldiv_seq_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .div_i    (op_is_div(op_in)),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .op_i     (op_q),
    .neg_res_i(neg_res_q),
    .neg_rem_i(neg_rem_q),
    .result_o (dp_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= MdMul;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= bus.rd_addr_i;
            cnt_q <= '0;
            // A zero divisor must not flip the all-ones quotient.
            neg_res_q <= op_is_div(op_in) ? (a_neg ^ b_neg) & ~b_zero : a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (shortcut) begin
              result_q <= sc_result;
              rd_out_q <= bus.rd_addr_i;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              result_q <= dp_result;
              rd_out_q <= rd_q;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall_o   = rst_ni & (((state_q == StIdle) & accept) | (state_q == StBusy));
  assign bus.busy_o    = (state_q != StIdle);
  assign bus.done_o    = done_q;
  assign bus.result_o  = result_q;
  assign bus.rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed table-driven bench for ex_muldiv_seq plus flush, reset and back-to-back sequences.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int NVec = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_seq #(
    .XLEN        (XLEN),
    .DIV_SHORTCUT(1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[NVec];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Issues one op and waits (bounded) for done_o. lat counts cycles from the start cycle.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rd_o,
                        output int lat, output logic stall_ok);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.rd_addr_i = rd;
    #1 stall_ok = (bus.stall_o === 1'b1);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 100) begin
      if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.stall_o !== 1'b0) stall_ok = 1'b0;
    res  = bus.result_o;
    rd_o = bus.rd_addr_o;
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  rd_o;
    int          lat;
    logic        stall_ok;
    int          seen;
    int          gap;

    vecs[0]  = '{MdMul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{MdMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{MdMulh,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[3]  = '{MdMulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{MdDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{MdRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{MdDivu,   32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{MdRemu,   32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{MdDivu,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{MdRem,    32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{MdDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{MdRem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{MdMul,    32'h12345678, 32'h10,       32'h23456780, 33};
    vecs[13] = '{MdDiv,    32'hFFFFFFFA, 32'd0,        32'hFFFFFFFF, 1};
    vecs[14] = '{MdRem,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
    vecs[15] = '{MdMulh,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33};
    vecs[16] = '{MdMulhu,  32'h80000000, 32'd4,        32'd2,        33};
    vecs[17] = '{MdDivu,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
    vecs[18] = '{MdRem,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[19] = '{MdDiv,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[20] = '{MdDivu,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[21] = '{MdRemu,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

    bus.start_i   = 1'b1;  // stall_o must stay low while in reset
    bus.op_i      = 3'd0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.rd_addr_i = '0;
    bus.flush_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    check("reset_rd", 32'(bus.rd_addr_o), 32'd0);
    check("reset_stall", 32'(bus.stall_o), 32'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, rd_o, lat, stall_ok);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(i + 1));
      check($sformatf("v%0d_stall", i), 32'(stall_ok), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done_o), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(bus.busy_o), 32'd0);
    end

    // Flush during BUSY: abort silently, outputs keep the previous result.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = MdMul;
    bus.a_i       = 32'd3;
    bus.b_i       = 32'd5;
    bus.rd_addr_i = 5'd30;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done_o === 1'b1) seen++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_kept", bus.result_o, 32'h80000000);
    check("flush_rd_kept", 32'(bus.rd_addr_o), 32'd22);
    run_op(MdMul, 32'd3, 32'd5, 5'd29, res, rd_o, lat, stall_ok);
    check("post_flush_result", res, 32'd15);
    check("post_flush_latency", 32'(lat), 32'd33);
    check("post_flush_rd", 32'(rd_o), 32'd29);

    // Reset mid-op, with start_i held high to exercise stall gating.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = MdDivu;
    bus.a_i       = 32'd100;
    bus.b_i       = 32'd7;
    bus.rd_addr_i = 5'd12;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (20) @(negedge clk);
    bus.start_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_done", 32'(bus.done_o), 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_rd", 32'(bus.rd_addr_o), 32'd0);
    check("midrst_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: start_i held high; DONE must not re-accept.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = MdMulhu;
    bus.a_i       = 32'hFFFFFFFF;
    bus.b_i       = 32'hFFFFFFFF;
    bus.rd_addr_i = 5'd9;
    @(negedge clk);
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_result", bus.result_o, 32'hFFFFFFFE);
    check("b2b_done_no_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    check("b2b_idle_busy", 32'(bus.busy_o), 32'd0);
    check("b2b_idle_stall", 32'(bus.stall_o), 32'd1);
    gap = 1;
    while (bus.done_o !== 1'b1 && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    bus.start_i = 1'b0;
    check("b2b_second_gap", 32'(gap), 32'd34);
    check("b2b_second_result", bus.result_o, 32'hFFFFFFFE);
    @(negedge clk);
    @(negedge clk);
    check("b2b_end_idle", 32'(bus.busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
